id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the pipelined MIPS core.
- Captures the decoded control bundle from the control unit, together with the operands and register specifiers from ID, and presents them registered to EX.
- Contains the load-use hazard detector, which generates stall and bubble insertion, and the branch/jump flush logic.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- DATA_W, 16, operand/immediate/PC width
- REG_AW, 4, register specifier width (16 registers, r0 hardwired zero)
- CNT_W, 16, width of the stall/flush event counters

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_regDest, id_jump, id_BranchEq, id_BranchNeq, id_BranchGt, id_BranchLt  in  1 each  control unit outputs
- id_memRead, id_memToReg, id_memWrite, id_ALUsrc, id_RegWrite  in  1 each  control unit outputs
- id_ALUop  in  4  control unit ALU operation
- id_rs, id_rt, id_rd  in  REG_AW each  register specifiers
- id_rs_data, id_rt_data  in  DATA_W each  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc_next  in  DATA_W  PC+1 of the ID instruction
- flush  in  1  taken branch/jump resolved in EX this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_<all control signals above>  out  same widths  registered control bundle
- ex_rs, ex_rt  out  REG_AW  registered specifiers, for forwarding
- ex_write_reg  out  REG_AW  destination: id_rd if id_regDest, else id_rt (muxed before the register)
- ex_rs_data, ex_rt_data, ex_imm, ex_pc_next  out  DATA_W  registered operands
- stall  out  1  combinational; holds PC and IF/ID this cycle
- stall_count, flush_count  out  CNT_W  event counters

Behaviour:
- Reset (rst=1 at a rising edge):
  - all ex_* outputs go to 0 and ex_valid=0.
  - Both counters go to 0.
  - stall=0 while ex_valid=0.
  - Reset overrides flush and stall in the same cycle.
- Normal operation: each rising edge loads every ex_* output from its id_* counterpart. Latency is 1 cycle.
- Rt-use: the ID instruction uses rt when (!id_ALUsrc) | id_memWrite | any id_Branch*.
- Hazard condition, evaluated combinationally:
  - haz = id_valid & ex_valid & ex_memRead & (ex_write_reg != 0) & ((ex_write_reg == id_rs) | (rt-use & ex_write_reg == id_rt)).
  - stall = haz & !flush.
- Bubble on stall: when stall=1, the next edge loads a bubble. A bubble is ex_valid=0 and all control outputs (including ALUop) = 0; data fields are don't-care and are held.
  - The stalled instruction stays in ID.
  - The next cycle sees ex_memRead=0, so the stall lasts exactly 1 cycle per load-use.
- Flush:
  - When flush=1, the next edge loads a bubble regardless of id_valid or haz.
  - Flush has priority over stall, and stall is forced to 0.
- Invalid input: when id_valid=0, the next edge loads a bubble.
- Counters:
  - stall_count increments on each edge where stall=1.
  - flush_count increments on each edge where flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Simultaneous flush and haz: flush_count increments, stall_count does not.
- No X propagation: all ex_* outputs are defined in every cycle after the first reset.

Test Plan:
- rst=1 for 2 cycles, then release -> all ex_* = 0, stall=0, both counters = 0.
- id_valid=1, opcode-0000 bundle (regDest=1, RegWrite=1, ALUop=0), rd=5, rt=3, rs_data=0x1234 -> after one edge: ex_write_reg=5, ex_rs_data=0x1234, ex_RegWrite=1, stall=0.
- Load-use on rs:
  - Stimulus: load (memRead=1, regDest=0, rt=7) followed by an add with rs=7.
  - Response: stall=1 for exactly one cycle; the next edge gives ex_valid=0 with all controls 0; the add then enters EX; stall_count=1.
- Load to r4 followed by addi (ALUsrc=1) with rt=4, rs=2 -> stall=0. Load to r0 followed by a use of r0 -> stall=0.
- Load-use hazard present with flush=1 in the same cycle -> stall=0, bubble inserted, flush_count=1, stall_count unchanged.
- Force stall_count to saturation (CNT_W=4 build, 20 load-use pairs) -> stall_count holds 15 and does not wrap.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS core.
// It also detects load-use hazards (stall plus bubble), applies branch/jump flushes and keeps saturating debug counters.
module id_ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_regDest,
  input  logic              id_jump,
  input  logic              id_BranchEq,
  input  logic              id_BranchNeq,
  input  logic              id_BranchGt,
  input  logic              id_BranchLt,
  input  logic              id_memRead,
  input  logic              id_memToReg,
  input  logic              id_memWrite,
  input  logic              id_ALUsrc,
  input  logic              id_RegWrite,
  input  logic [3:0]        id_ALUop,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_next,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_regDest,
  output logic              ex_jump,
  output logic              ex_BranchEq,
  output logic              ex_BranchNeq,
  output logic              ex_BranchGt,
  output logic              ex_BranchLt,
  output logic              ex_memRead,
  output logic              ex_memToReg,
  output logic              ex_memWrite,
  output logic              ex_ALUsrc,
  output logic              ex_RegWrite,
  output logic [3:0]        ex_ALUop,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_next,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int unsigned CTRL_W = 15;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;
  logic [REG_AW-1:0] r_rs, r_rt, r_write_reg;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm, r_pc_next;
  logic [CNT_W-1:0]  r_stall_count, r_flush_count;

  logic              w_uses_rt;
  logic              w_haz;
  logic              w_stall;
  logic              w_load;
  logic [REG_AW-1:0] w_write_reg;
  logic [CTRL_W-1:0] w_id_ctrl;

  // Hazard detection and next-entry selection
  always_comb begin
    w_id_ctrl   = {id_regDest, id_jump, id_BranchEq, id_BranchNeq, id_BranchGt,
                   id_BranchLt, id_memRead, id_memToReg, id_memWrite, id_ALUsrc,
                   id_RegWrite, id_ALUop};
    w_uses_rt   = ~id_ALUsrc | id_memWrite | id_BranchEq | id_BranchNeq |
                  id_BranchGt | id_BranchLt;
    w_haz       = id_valid & r_valid & r_ctrl[8] & (r_write_reg != '0) &
                  ((r_write_reg == id_rs) | (w_uses_rt & (r_write_reg == id_rt)));
    w_stall     = w_haz & ~flush;
    w_load      = id_valid & ~flush & ~w_haz;
    w_write_reg = id_regDest ? id_rd : id_rt;
  end

  // Pipeline register; bubbles clear valid and control but hold the data fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_pc_next   <= '0;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_ctrl      <= w_id_ctrl;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_write_reg <= w_write_reg;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_pc_next   <= id_pc_next;
    end else begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
    end
  end

  // Saturating debug event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != CNT_MAX))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (flush && (r_flush_count != CNT_MAX))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign {ex_regDest, ex_jump, ex_BranchEq, ex_BranchNeq, ex_BranchGt,
          ex_BranchLt, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUsrc,
          ex_RegWrite, ex_ALUop} = r_ctrl;
  assign ex_valid     = r_valid;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_write_reg = r_write_reg;
  assign ex_rs_data   = r_rs_data;
  assign ex_rt_data   = r_rt_data;
  assign ex_imm       = r_imm;
  assign ex_pc_next   = r_pc_next;
  assign stall        = w_stall;
  assign stall_count  = r_stall_count;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use, flush and saturation cases, then randomized traffic.
// Every cycle's outputs are compared against a behavioural pipeline model.
module tb_id_ex_stage;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int SAT = 15;
  // control bit positions within ctl
  localparam int B_REGDEST = 14, B_MEMREAD = 8, B_MEMTOREG = 7, B_MEMWRITE = 6;
  localparam int B_ALUSRC = 5, B_REGWRITE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [14:0] ctl = '0;
  logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc_next = '0;
  logic flush = 1'b0;

  logic ex_valid, ex_regDest, ex_jump, ex_BranchEq, ex_BranchNeq, ex_BranchGt, ex_BranchLt;
  logic ex_memRead, ex_memToReg, ex_memWrite, ex_ALUsrc, ex_RegWrite;
  logic [3:0] ex_ALUop;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_write_reg;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_next;
  logic stall;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [14:0] dut_ctl;

  assign dut_ctl = {ex_regDest, ex_jump, ex_BranchEq, ex_BranchNeq, ex_BranchGt, ex_BranchLt,
                    ex_memRead, ex_memToReg, ex_memWrite, ex_ALUsrc, ex_RegWrite, ex_ALUop};

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_regDest(ctl[14]), .id_jump(ctl[13]), .id_BranchEq(ctl[12]), .id_BranchNeq(ctl[11]),
    .id_BranchGt(ctl[10]), .id_BranchLt(ctl[9]), .id_memRead(ctl[8]), .id_memToReg(ctl[7]),
    .id_memWrite(ctl[6]), .id_ALUsrc(ctl[5]), .id_RegWrite(ctl[4]), .id_ALUop(ctl[3:0]),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc_next(id_pc_next), .flush(flush),
    .ex_valid(ex_valid), .ex_regDest(ex_regDest), .ex_jump(ex_jump),
    .ex_BranchEq(ex_BranchEq), .ex_BranchNeq(ex_BranchNeq), .ex_BranchGt(ex_BranchGt),
    .ex_BranchLt(ex_BranchLt), .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg),
    .ex_memWrite(ex_memWrite), .ex_ALUsrc(ex_ALUsrc), .ex_RegWrite(ex_RegWrite),
    .ex_ALUop(ex_ALUop), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_pc_next(ex_pc_next), .stall(stall), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Behavioural view of what EX should hold
  bit m_valid = 1'b0;
  logic [14:0] m_ctrl = '0;
  int m_rs = 0, m_rt = 0, m_wr = 0, m_rsd = 0, m_rtd = 0, m_imm = 0, m_pc = 0;
  int m_sc = 0, m_fc = 0;
  bit last_stall = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit exp_stall();
    bit uses_rt, haz;
    uses_rt = !ctl[B_ALUSRC] || ctl[B_MEMWRITE] || (ctl[12:9] != 4'b0);
    haz = id_valid && m_valid && m_ctrl[B_MEMREAD] && (m_wr != 0) &&
          ((m_wr == int'(id_rs)) || (uses_rt && (m_wr == int'(id_rt))));
    return haz && !flush;
  endfunction

  task automatic model_step();
    bit s;
    s = exp_stall();
    last_stall = s;
    if (rst) begin
      m_valid = 0; m_ctrl = '0; m_rs = 0; m_rt = 0; m_wr = 0;
      m_rsd = 0; m_rtd = 0; m_imm = 0; m_pc = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (s && m_sc < SAT) m_sc++;
      if (flush && m_fc < SAT) m_fc++;
      if (id_valid && !flush && !s) begin
        m_valid = 1; m_ctrl = ctl; m_rs = int'(id_rs); m_rt = int'(id_rt);
        m_wr = ctl[B_REGDEST] ? int'(id_rd) : int'(id_rt);
        m_rsd = int'(id_rs_data); m_rtd = int'(id_rt_data);
        m_imm = int'(id_imm); m_pc = int'(id_pc_next);
      end else begin
        m_valid = 0; m_ctrl = '0;
      end
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_valid", int'(ex_valid), int'(m_valid));
      chk("ex_ctrl", int'(dut_ctl), int'(m_ctrl));
      chk("stall", int'(stall), int'(exp_stall()));
      chk("stall_count", int'(stall_count), m_sc);
      chk("flush_count", int'(flush_count), m_fc);
      if (m_valid) begin
        chk("ex_rs", int'(ex_rs), m_rs);
        chk("ex_rt", int'(ex_rt), m_rt);
        chk("ex_write_reg", int'(ex_write_reg), m_wr);
        chk("ex_rs_data", int'(ex_rs_data), m_rsd);
        chk("ex_rt_data", int'(ex_rt_data), m_rtd);
        chk("ex_imm", int'(ex_imm), m_imm);
        chk("ex_pc_next", int'(ex_pc_next), m_pc);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic instr(input logic [14:0] c, input int rs, input int rt, input int rd,
                       input int rsd);
    id_valid = 1'b1; ctl = c;
    id_rs = REG_AW'(rs); id_rt = REG_AW'(rt); id_rd = REG_AW'(rd);
    id_rs_data = DATA_W'(rsd); id_rt_data = DATA_W'(rsd ^ 16'h5a5a);
    id_imm = DATA_W'(rd * 3); id_pc_next = id_pc_next + DATA_W'(1);
  endtask

  logic [14:0] c_rtype, c_load, c_addi;

  initial begin
    c_rtype = '0; c_rtype[B_REGDEST] = 1'b1; c_rtype[B_REGWRITE] = 1'b1;
    c_load = '0; c_load[B_MEMREAD] = 1'b1; c_load[B_MEMTOREG] = 1'b1;
    c_load[B_ALUSRC] = 1'b1; c_load[B_REGWRITE] = 1'b1;
    c_addi = '0; c_addi[B_ALUSRC] = 1'b1; c_addi[B_REGWRITE] = 1'b1; c_addi[3:0] = 4'h2;

    // reset for two edges
    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_valid", int'(ex_valid), 0);
    chk("rst_ctl", int'(dut_ctl), 0);
    chk("rst_data", int'(ex_rs_data), 0);
    chk("rst_wr", int'(ex_write_reg), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_counts", int'(stall_count) + int'(flush_count), 0);

    // plain R-type
    instr(c_rtype, 1, 3, 5, 16'h1234);
    cycle();
    chk("rtype_wr", int'(ex_write_reg), 5);
    chk("rtype_rsd", int'(ex_rs_data), 16'h1234);
    chk("rtype_regwrite", int'(ex_RegWrite), 1);
    chk("rtype_valid", int'(ex_valid), 1);

    // load r7 then add using rs=7: one-cycle stall, one bubble
    instr(c_load, 2, 7, 0, 16'h0040);
    cycle();
    instr(c_rtype, 7, 1, 8, 16'h0077);
    #1 chk("lu_stall", int'(stall), 1);
    cycle();
    chk("lu_bubble_valid", int'(ex_valid), 0);
    chk("lu_bubble_ctl", int'(dut_ctl), 0);
    chk("lu_stall_count", int'(stall_count), 1);
    #1 chk("lu_stall_cleared", int'(stall), 0);
    cycle();
    chk("lu_add_enters", int'(ex_write_reg), 8);
    chk("lu_add_valid", int'(ex_valid), 1);

    // load r4 then addi reading only rs=2
    instr(c_load, 1, 4, 0, 16'h0010);
    cycle();
    instr(c_addi, 2, 4, 0, 16'h0020);
    #1 chk("addi_no_stall", int'(stall), 0);
    cycle();
    // load r0 then a use of r0
    instr(c_load, 1, 0, 0, 16'h0011);
    cycle();
    instr(c_rtype, 0, 0, 9, 16'h0022);
    #1 chk("r0_no_stall", int'(stall), 0);
    cycle();

    // load-use coinciding with flush
    instr(c_load, 1, 6, 0, 16'h0033);
    cycle();
    instr(c_rtype, 6, 2, 10, 16'h0044);
    flush = 1'b1;
    #1 chk("flush_no_stall", int'(stall), 0);
    cycle();
    flush = 1'b0;
    chk("flush_bubble", int'(ex_valid), 0);
    chk("flush_count_1", int'(flush_count), 1);
    chk("flush_stall_count", int'(stall_count), 1);

    // 20 load-use pairs drive the 4-bit stall counter to saturation
    for (int i = 0; i < 20; i++) begin
      instr(c_load, 1, 9, 0, i);
      cycle();
      instr(c_rtype, 9, 3, 11, i + 1);
      cycle();
      cycle();
    end
    chk("stall_sat", int'(stall_count), 15);

    // randomized traffic; the stalled instruction is held in ID like a real IF/ID
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (!last_stall) begin
        id_valid = ($urandom_range(0, 6) != 0);
        ctl = 15'($urandom);
        id_rs = REG_AW'($urandom_range(0, 3));
        id_rt = REG_AW'($urandom_range(0, 3));
        id_rd = REG_AW'($urandom_range(0, 15));
        id_rs_data = DATA_W'($urandom);
        id_rt_data = DATA_W'($urandom);
        id_imm = DATA_W'($urandom);
        id_pc_next = DATA_W'($urandom);
      end
      cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
